// File: rtl/contador_sincrono_t_ff.sv
// One bit of the synchronous counter: a T flip-flop with a dominant synchronous clear.
module t_ff (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Clear wins over toggle; without either the bit holds.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/contador_sincrono.sv
// Free-running synchronous up-counter built from WIDTH T flip-flops sharing one clock.
module contador_sincrono #(
  parameter int unsigned WIDTH = 4
) (
  output logic [WIDTH-1:0] q,
  input  logic             clr,
  input  logic             clk
);

  // t_chain[i] is the AND of all lower bits; bit 0 toggles on every counting edge.
  logic [WIDTH-1:0] t_chain;
  logic [WIDTH-1:0] q_bits;

  assign t_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign t_chain[gi] = t_chain[gi-1] & q_bits[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      t_ff u_t_ff (
        .clk (clk),
        .clr (clr),
        .t   (t_chain[gi]),
        .q   (q_bits[gi])
      );
    end
  endgenerate

  assign q = q_bits;

endmodule

// File: tb/tb_contador_sincrono.sv
// Scoreboard bench for contador_sincrono: default 4-bit build plus a 1-bit build on the same clr.
module tb_contador_sincrono;

  localparam int unsigned W4 = 4;
  localparam int unsigned W1 = 1;

  logic          clk;
  logic          clr;
  logic [W4-1:0] q4;
  logic [W1-1:0] q1;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [W4-1:0] model4;
  logic [W1-1:0] model1;
  logic [W4-1:0] exp4_q[$];
  logic [W1-1:0] exp1_q[$];

  contador_sincrono #(.WIDTH(W4)) dut (
    .q   (q4),
    .clr (clr),
    .clk (clk)
  );

  contador_sincrono #(.WIDTH(W1)) dut_w1 (
    .q   (q1),
    .clr (clr),
    .clk (clk)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive clr, let one rising edge pass, push the expected result and compare #1 later.
  task automatic tick(input logic c, input string tag);
    logic [W4-1:0] e4;
    logic [W1-1:0] e1;
    clr = c;
    @(posedge clk);
    model4 = c ? '0 : W4'(model4 + 1'b1);
    model1 = c ? '0 : W1'(model1 + 1'b1);
    exp4_q.push_back(model4);
    exp1_q.push_back(model1);
    #1;
    e4 = exp4_q.pop_front();
    e1 = exp1_q.pop_front();
    check_val(tag, 32'(q4), 32'(e4));
    check_val({tag, "_w1"}, 32'(q1), 32'(e1));
  endtask

  task automatic run_count(input int unsigned n, input string tag);
    for (int i = 0; i < int'(n); i++) tick(1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    model4 = '0;
    model1 = '0;
    clr    = 1'b1;

    // Reset: edge at 10 ns, then held for one more edge.
    tick(1'b1, "reset");
    tick(1'b1, "reset_hold");
    check_val("reset_abs", 32'(q4), 32'd0);

    // Count 1..15, then wrap to 0 on the 16th edge.
    run_count(1, "count_first");
    check_val("count_first_abs", 32'(q4), 32'd1);
    run_count(14, "count");
    check_val("max_abs", 32'(q4), 32'd15);
    run_count(1, "wrap");
    check_val("wrap_abs", 32'(q4), 32'd0);
    run_count(14, "count_after_wrap");
    check_val("edge30_abs", 32'(q4), 32'd14);

    // Reset mid-count at 9.
    tick(1'b1, "reset2");
    run_count(9, "to_nine");
    check_val("nine_abs", 32'(q4), 32'd9);
    tick(1'b1, "clr_mid");
    check_val("clr_mid_abs", 32'(q4), 32'd0);
    tick(1'b0, "resume");
    check_val("resume_abs", 32'(q4), 32'd1);

    // Clear at maximum must give 0, then 1.
    run_count(14, "to_max");
    check_val("at_max_abs", 32'(q4), 32'd15);
    tick(1'b1, "clr_at_max");
    check_val("clr_at_max_abs", 32'(q4), 32'd0);
    tick(1'b0, "after_max_clr");
    check_val("after_max_clr_abs", 32'(q4), 32'd1);

    // Glitch on clr between edges must not disturb the count.
    run_count(4, "pre_glitch");
    #3 clr = 1'b1;
    #3 clr = 1'b0;
    #1;
    check_val("glitch_hold", 32'(q4), 32'(model4));
    run_count(3, "post_glitch");
    check_val("post_glitch_abs", 32'(q4), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
